uart_byte_receiver: RTL and testbench

Serial-to-byte receiver for the instruction-load path: oversamples the asynchronous `rx` line, reassembles 8N1 frames (LSB first), and presents each byte on `uart_packet` under a four-phase `packet_ready`/`packet_ack` handshake to the instruction loader. A one-byte holding register absorbs a byte that completes while the loader is still busy.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_byte_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_uart_byte_receiver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART byte receiver: FSM state encoding,
//   frame constants and the bit-period derivation.
//   Optional feature macro: UART_PARITY_EN (adds the PARITY state usage, 8E1).
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } uart_state_e;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Two-flop synchronizer for the asynchronous serial line. Both flops
//   preset to 1 (line idle) so reset never looks like a start bit.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   rx_i  in  asynchronous serial input
//   rxs_o out synchronized serial line
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_i,
   output logic rxs_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
      end
   end

   assign rxs_o = sync_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver
//   Oversampling UART receiver (8N1, or 8E1 when UART_PARITY_EN is defined)
//   that hands each byte to the instruction loader over a four-phase
//   packet_ready/packet_ack handshake, with a one-byte holding register.
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   rx             in   asynchronous serial line, idle high
//   packet_ack     in   loader acknowledge
//   packet_ready   out  uart_packet holds a valid byte
//   uart_packet    out  received byte
//   framing_error  out  one-cycle pulse, stop bit sampled low
//   overrun        out  one-cycle pulse, completed byte dropped
//   parity_error   out  one-cycle pulse, even-parity mismatch (UART_PARITY_EN only)
//
// state     | meaning
// S_IDLE    | line idle, waiting for a low level
// S_START   | timing to mid start bit, rejecting glitches
// S_DATA    | sampling 8 data bits, LSB first
// S_PARITY  | sampling the even-parity bit (UART_PARITY_EN only)
// S_STOP    | sampling the stop bit
// S_WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_byte_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx,
   input  logic                      packet_ack,
   output logic                      packet_ready,
   output logic [UART_DATA_BITS-1:0] uart_packet,
   output logic                      framing_error,
`ifdef UART_PARITY_EN
   output logic                      parity_error,
`endif
   output logic                      overrun
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 16) begin : g_cpb_check
      $error("uart_byte_receiver: CLKS_PER_BIT must be at least 16");
   end

`ifdef UART_PARITY_EN
   localparam uart_state_e AFTER_DATA = S_PARITY;
`else
   localparam uart_state_e AFTER_DATA = S_STOP;
`endif

   logic                      rxs;
   uart_state_e               state_q;
   logic [CNT_W-1:0]          baud_cnt_q;
   logic [2:0]                bit_cnt_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      framing_error_q;
   logic                      byte_done_d;
   logic                      slot_free_d;
   logic                      packet_ready_q;
   logic [UART_DATA_BITS-1:0] packet_q;
   logic [UART_DATA_BITS-1:0] hold_q;
   logic                      hold_full_q;
   logic                      overrun_q;
`ifdef UART_PARITY_EN
   logic                      parity_bad_q;
   logic                      parity_error_q;
`endif

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .rx_i  (rx),
      .rxs_o (rxs)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         baud_cnt_q      <= '0;
         bit_cnt_q       <= '0;
         shift_q         <= '0;
         framing_error_q <= 1'b0;
`ifdef UART_PARITY_EN
         parity_bad_q    <= 1'b0;
         parity_error_q  <= 1'b0;
`endif
      end else begin
         framing_error_q <= 1'b0;
`ifdef UART_PARITY_EN
         parity_error_q  <= 1'b0;
`endif
         unique case (state_q)
            S_IDLE: begin
               if (!rxs) begin
                  state_q    <= S_START;
                  baud_cnt_q <= '0;
               end
            end
            S_START: begin
               if (baud_cnt_q == CNT_HALF) begin
                  baud_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  state_q    <= rxs ? S_IDLE : S_DATA;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_cnt_q == CNT_LAST) begin
                  baud_cnt_q <= '0;
                  shift_q    <= {rxs, shift_q[UART_DATA_BITS-1:1]};
                  bit_cnt_q  <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= AFTER_DATA;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
               if (baud_cnt_q == CNT_LAST) begin
                  baud_cnt_q <= '0;
                  state_q    <= S_STOP;
                  if ((^shift_q) != rxs) begin
                     parity_bad_q   <= 1'b1;
                     parity_error_q <= 1'b1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (baud_cnt_q == CNT_LAST) begin
                  baud_cnt_q <= '0;
`ifdef UART_PARITY_EN
                  parity_bad_q <= 1'b0;
`endif
                  if (rxs) begin
                     state_q <= S_IDLE;
                  end else begin
                     framing_error_q <= 1'b1;
                     state_q         <= S_WAIT_HIGH;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               if (rxs) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // A byte completes on the stop-bit sample cycle, so delivery below
   // registers it in the same edge and packet_ready follows one cycle later.
`ifdef UART_PARITY_EN
   assign byte_done_d = (state_q == S_STOP) && (baud_cnt_q == CNT_LAST) && rxs && !parity_bad_q;
`else
   assign byte_done_d = (state_q == S_STOP) && (baud_cnt_q == CNT_LAST) && rxs;
`endif

   // Output slot is free only once the loader has also dropped its ack.
   assign slot_free_d = !packet_ready_q && !packet_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         packet_ready_q <= 1'b0;
         packet_q       <= '0;
         hold_q         <= '0;
         hold_full_q    <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (packet_ready_q && packet_ack) packet_ready_q <= 1'b0;

         if (slot_free_d && hold_full_q) begin
            // Drain holding byte; a byte completing now takes its place.
            packet_q       <= hold_q;
            packet_ready_q <= 1'b1;
            hold_full_q    <= byte_done_d;
            if (byte_done_d) hold_q <= shift_q;
         end else if (slot_free_d && byte_done_d) begin
            packet_q       <= shift_q;
            packet_ready_q <= 1'b1;
         end else if (byte_done_d) begin
            if (!hold_full_q) begin
               hold_q      <= shift_q;
               hold_full_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end
      end
   end

   assign packet_ready  = packet_ready_q;
   assign uart_packet   = packet_q;
   assign framing_error = framing_error_q;
   assign overrun       = overrun_q;
`ifdef UART_PARITY_EN
   assign parity_error  = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_byte_receiver.sv
module tb_uart_byte_receiver;

   localparam int CPB = 16;
`ifdef UART_PARITY_EN
   localparam int NPAR = 1;
`else
   localparam int NPAR = 0;
`endif
   // Posedge of stop-bit sample relative to the first posedge of the start bit:
   // 2 sync + 1 IDLE detect + half bit, then one bit period per remaining bit.
   localparam int STOP_OFS = 10 + CPB * (9 + NPAR);

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       packet_ack;
   logic       packet_ready;
   logic [7:0] uart_packet;
   logic       framing_error;
   logic       overrun;
`ifdef UART_PARITY_EN
   logic       parity_error;
   logic       par_flip;
   int         pe_cnt = 0;
`endif

   uart_byte_receiver #(.CLK_FREQ(CPB), .BAUD(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .packet_ack    (packet_ack),
      .packet_ready  (packet_ready),
      .uart_packet   (uart_packet),
      .framing_error (framing_error),
`ifdef UART_PARITY_EN
      .parity_error  (parity_error),
`endif
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         last_start = 0;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   bit         lat_en = 1'b0;
   bit         auto_ack = 1'b1;
   logic       ack_man = 1'b0;
   logic       ack_prev = 1'b0;
   logic [7:0] sb[$];

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      ack_prev <= packet_ack;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Loader model: ack follows packet_ready one cycle later in auto mode.
   initial begin
      packet_ack = 1'b0;
      forever begin
         @(negedge clk);
         packet_ack = auto_ack ? packet_ready : ack_man;
      end
   end

   // Output monitor: compare each newly presented byte against the scoreboard.
   initial begin
      logic rdy_prev;
      rdy_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (framing_error === 1'b1) fe_cnt++;
         if (overrun === 1'b1) ov_cnt++;
`ifdef UART_PARITY_EN
         if (parity_error === 1'b1) pe_cnt++;
`endif
         if (packet_ready === 1'b1 && rdy_prev !== 1'b1) begin
            check_eq("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) check_eq("rx_byte", uart_packet, sb.pop_front());
            check_eq("ready_vs_ack", ack_prev, 0);
            if (lat_en) check_eq("latency", cyc - last_start, STOP_OFS);
         end
         rdy_prev = packet_ready;
      end
   end

   task automatic send_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v, input bit exp_ok);
      last_start = cyc + 1;
      if (exp_ok) sb.push_back(b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
      send_bit((^b) ^ par_flip);
`endif
      send_bit(stop_v);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_sb_empty(input string tag, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check_eq(tag, sb.size(), 0);
   endtask

   initial begin
      int fe0, ov0;
      rst = 1'b1;
      rx  = 1'b1;
`ifdef UART_PARITY_EN
      par_flip = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_eq("rst_ready", packet_ready, 0);
      check_eq("rst_packet", uart_packet, 0);
      check_eq("rst_fe", framing_error, 0);
      check_eq("rst_ov", overrun, 0);
      rst = 1'b0;
      idle(5);

      // Single byte, auto ack, latency checked.
      lat_en = 1'b1;
      send_byte(8'hA5, 1'b1, 1'b1);
      wait_sb_empty("drain_a5", 50);
      lat_en = 1'b0;
      idle(10);
      check_eq("a5_fe", fe_cnt, 0);
      check_eq("a5_ov", ov_cnt, 0);

      // Back-to-back frames with ack held low: output, hold, overrun.
      auto_ack = 1'b0;
      ack_man  = 1'b0;
      @(negedge clk);
      ov0 = ov_cnt;
      send_byte(8'h3C, 1'b1, 1'b1);
      send_byte(8'h81, 1'b1, 1'b1);
      send_byte(8'hFF, 1'b1, 1'b0);
      idle(5);
      check_eq("b2b_overrun", ov_cnt - ov0, 1);
      check_eq("b2b_ready_hold", packet_ready, 1);
      check_eq("b2b_out_3c", uart_packet, 8'h3C);
      ack_man = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (packet_ready === 1'b0) break;
         @(negedge clk);
      end
      check_eq("ack_clears_ready", packet_ready, 0);
      ack_man = 1'b0;
      wait_sb_empty("drain_81", 20);
      check_eq("out_81", uart_packet, 8'h81);
      auto_ack = 1'b1;
      idle(10);
      check_eq("after_81_ready", packet_ready, 0);

      // Framing error, line held low, then recovery.
      fe0 = fe_cnt;
      send_byte(8'h55, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (40) @(negedge clk);
      check_eq("fe_pulse", fe_cnt - fe0, 1);
      check_eq("fe_no_ready", packet_ready, 0);
      idle(CPB);
      send_byte(8'h12, 1'b1, 1'b1);
      wait_sb_empty("drain_12", 50);
      idle(10);

      // Start-bit glitch rejection.
      fe0 = fe_cnt;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      idle(40);
      check_eq("glitch_no_ready", packet_ready, 0);
      check_eq("glitch_no_fe", fe_cnt - fe0, 0);
      send_byte(8'h7E, 1'b1, 1'b1);
      wait_sb_empty("drain_7e", 50);
      idle(10);

      // Reset in the middle of bit 4 of 0xC3.
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(((8'hC3 >> i) & 8'h01) != 0);
      rx = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      check_eq("midrst_ready", packet_ready, 0);
      check_eq("midrst_packet", uart_packet, 0);
      check_eq("midrst_fe", framing_error, 0);
      check_eq("midrst_ov", overrun, 0);
      rst = 1'b0;
      idle(20);
      check_eq("midrst_no_ready", packet_ready, 0);
      send_byte(8'h01, 1'b1, 1'b1);
      wait_sb_empty("drain_01", 50);
      idle(10);

`ifdef UART_PARITY_EN
      par_flip = 1'b0;
      send_byte(8'h0F, 1'b1, 1'b1);
      wait_sb_empty("drain_0f", 50);
      idle(10);
      fe0 = pe_cnt;
      par_flip = 1'b1;
      send_byte(8'h0F, 1'b1, 1'b0);
      idle(10);
      par_flip = 1'b0;
      check_eq("pe_pulse", pe_cnt - fe0, 1);
      check_eq("pe_no_ready", packet_ready, 0);
`endif

      check_eq("total_fe", fe_cnt, 1);
      check_eq("total_ov", ov_cnt, 1);
      check_eq("sb_final", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
